// File: rtl/mon_pkg.sv
// Shared definitions for the monitor host: op codes, FSM states, error codes and
// the header byte layout that is sent ahead of every command.
package mon_pkg;

    localparam int unsigned HDR_LEN = 6;

    typedef enum logic [1:0] {
        OP_ILL  = 2'd0,
        OP_LOAD = 2'd1,
        OP_DUMP = 2'd2,
        OP_EXEC = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ECHO    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ILLEGAL = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_TX,
        ST_HDR_ECHO,
        ST_LD_TX,
        ST_LD_ECHO,
        ST_DP_RX,
        ST_FIN,
        ST_ERR
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [23:0] addr;
        logic [15:0] len;
    } cmd_t;

    // Header byte idx of a command: op, addr MSB first, len MSB first.
    function automatic logic [7:0] hdr_byte(input cmd_t c, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:    b = {6'd0, c.op};
            3'd1:    b = c.addr[23:16];
            3'd2:    b = c.addr[15:8];
            3'd3:    b = c.addr[7:0];
            3'd4:    b = c.len[15:8];
            3'd5:    b = c.len[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mon_timeout.sv
// Idle watchdog: reloads on i_load, parks at zero on i_clear, and flags expiry on
// the last cycle of the window so the owner can leave on the following edge.
module mon_timeout
    import mon_pkg::*;
#(
    parameter int unsigned CYCLES = 1200000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_clear,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(CYCLES);
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_expired = (r_cnt == CW'(1));

endmodule

// File: rtl/mon_host.sv
// Monitor host: sends a 6-byte echoed header over a UART byte stream, then streams
// an echoed LOAD payload or collects DUMP data, reporting done/error per command.
module mon_host
    import mon_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [23:0] cmd_addr,
    input  logic [15:0] cmd_len,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    state_e      r_state;
    cmd_t        r_cmd;
    logic [2:0]  r_idx;
    logic [7:0]  r_sent;
    logic [15:0] r_rem;
    logic [7:0]  r_rd_data;
    logic        r_rd_valid;
    err_e        r_err_code;

    logic w_wait;
    logic w_load;
    logic w_clear;
    logic w_expired;

    // Watchdog runs only while waiting on rx; every accepted rx byte restarts it.
    assign w_wait  = (r_state == ST_HDR_ECHO) || (r_state == ST_LD_ECHO) || (r_state == ST_DP_RX);
    assign w_load  = (w_wait && rx_valid)
                   || ((r_state == ST_HDR_TX) && tx_ready)
                   || ((r_state == ST_LD_TX) && wr_valid && tx_ready);
    assign w_clear = !w_wait;

    mon_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .i_clk     (CLK),
        .i_rst_n   (reset_n),
        .i_load    (w_load),
        .i_clear   (w_clear),
        .o_expired (w_expired)
    );

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_FIN);
    assign error     = (r_state == ST_ERR);
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign err_code  = r_err_code;

    // LOAD payload flows straight from the source to the transmitter.
    always_comb begin
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        wr_ready = 1'b0;
        case (r_state)
            ST_HDR_TX: begin
                tx_valid = 1'b1;
                tx_byte  = hdr_byte(r_cmd, r_idx);
            end
            ST_LD_TX: begin
                tx_valid = wr_valid;
                tx_byte  = wr_data;
                wr_ready = tx_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cmd      <= '0;
            r_idx      <= '0;
            r_sent     <= '0;
            r_rem      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd.op   <= op_e'(cmd_op);
                        r_cmd.addr <= cmd_addr;
                        r_cmd.len  <= cmd_len;
                        r_rem      <= cmd_len;
                        r_idx      <= '0;
                        if (op_e'(cmd_op) == OP_ILL) begin
                            r_err_code <= ERR_ILLEGAL;
                            r_state    <= ST_ERR;
                        end else begin
                            r_state <= ST_HDR_TX;
                        end
                    end
                end
                ST_HDR_TX: begin
                    if (tx_ready) begin
                        r_sent  <= hdr_byte(r_cmd, r_idx);
                        r_state <= ST_HDR_ECHO;
                    end
                end
                ST_HDR_ECHO: begin
                    if (rx_valid) begin
                        if (rx_byte != r_sent) begin
                            r_err_code <= ERR_ECHO;
                            r_state    <= ST_ERR;
                        end else if (r_idx == 3'(HDR_LEN - 1)) begin
                            case (r_cmd.op)
                                OP_LOAD: r_state <= (r_rem == 16'd0) ? ST_FIN : ST_LD_TX;
                                OP_DUMP: r_state <= (r_rem == 16'd0) ? ST_FIN : ST_DP_RX;
                                default: r_state <= ST_FIN;
                            endcase
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= ST_HDR_TX;
                        end
                    end else if (w_expired) begin
                        r_err_code <= ERR_TIMEOUT;
                        r_state    <= ST_ERR;
                    end
                end
                ST_LD_TX: begin
                    if (wr_valid && tx_ready) begin
                        r_sent  <= wr_data;
                        r_state <= ST_LD_ECHO;
                    end
                end
                ST_LD_ECHO: begin
                    if (rx_valid) begin
                        if (rx_byte != r_sent) begin
                            r_err_code <= ERR_ECHO;
                            r_state    <= ST_ERR;
                        end else begin
                            r_rem   <= r_rem - 16'd1;
                            r_state <= (r_rem == 16'd1) ? ST_FIN : ST_LD_TX;
                        end
                    end else if (w_expired) begin
                        r_err_code <= ERR_TIMEOUT;
                        r_state    <= ST_ERR;
                    end
                end
                ST_DP_RX: begin
                    if (rx_valid) begin
                        r_rd_data  <= rx_byte;
                        r_rd_valid <= 1'b1;
                        r_rem      <= r_rem - 16'd1;
                        if (r_rem == 16'd1) begin
                            r_state <= ST_FIN;
                        end
                    end else if (w_expired) begin
                        r_err_code <= ERR_TIMEOUT;
                        r_state    <= ST_ERR;
                    end
                end
                ST_FIN:  r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mon_host.sv
// Bench for mon_host: a randomized echoing UART responder drives each command and
// the observed byte streams and pulses are compared against a header/payload model.
module tb_mon_host;

    typedef logic [7:0] b8_t;

    localparam int unsigned TO = 100;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [23:0] cmd_addr = 24'd0;
    logic [15:0] cmd_len = 16'd0;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        rx_valid = 1'b0;
    logic [7:0]  wr_data = 8'd0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    mon_host #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    b8_t tx_q[$], rd_q[$], payload[$], dumpd[$], exp_tx[$], exp_rd[$];
    int  done_n, err_n, err_edge, last_rx_edge, acc_edge, budget_used;
    logic [1:0] last_ec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input b8_t obs[$], input b8_t exp[$]);
        chk({tag, "_count"}, 32'(obs.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < obs.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(obs[i]), 32'(exp[i]));
    endtask

    // Expected tx stream: first n_hdr header bytes, then the LOAD payload if any.
    task automatic model(input logic [1:0] op, input logic [23:0] a, input logic [15:0] l,
                         input int n_hdr, input bit with_pl, input int n_rd);
        b8_t h[6];
        h[0] = {6'd0, op};
        h[1] = b8_t'(a >> 16);
        h[2] = b8_t'(a >> 8);
        h[3] = b8_t'(a);
        h[4] = b8_t'(l >> 8);
        h[5] = b8_t'(l);
        exp_tx.delete();
        exp_rd.delete();
        for (int i = 0; i < n_hdr; i++) exp_tx.push_back(h[i]);
        if (with_pl) foreach (payload[i]) exp_tx.push_back(payload[i]);
        for (int i = 0; i < n_rd; i++) exp_rd.push_back(dumpd[i]);
    endtask

    // One command with an echoing responder; bad_idx corrupts that tx byte's echo,
    // dstop limits DUMP data bytes sent, abort_tx returns early after that many tx bytes.
    task automatic run(input logic [1:0] op, input logic [23:0] addr, input logic [15:0] len,
                       input int bad_idx, input int dstop, input int abort_tx);
        int  e = 0, pidx = 0, didx = 0, ntx = 0, necho = 0, pdel = 0, post = 0, budget = 0;
        bit  pend = 0, fin = 0;
        b8_t pbyte = 8'h00;
        tx_q.delete();
        rd_q.delete();
        done_n = 0; err_n = 0; err_edge = -1; last_rx_edge = -1; last_ec = 2'd0;
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge CLK); e++; acc_edge = e;
        @(negedge CLK);
        cmd_valid = 1'b0; cmd_op = 2'd0;
        while (post < 4 && budget < 3000 && !(abort_tx >= 0 && ntx >= abort_tx)) begin
            if (rd_valid) rd_q.push_back(rd_data);
            if (done) done_n++;
            if (error) begin err_n++; err_edge = e; last_ec = err_code; end
            if (done || error) fin = 1;
            if (fin) post++;
            tx_ready = ($urandom_range(0, 3) != 0);
            wr_valid = (pidx < payload.size()) && ($urandom_range(0, 2) != 0);
            wr_data  = (pidx < payload.size()) ? payload[pidx] : 8'h00;
            rx_valid = 1'b0;
            rx_byte  = b8_t'($urandom);
            if (pend) begin
                if (pdel == 0) begin
                    rx_valid = 1'b1; rx_byte = pbyte; pend = 0; necho++; last_rx_edge = e + 1;
                end else pdel--;
            end else if (op == 2'd2 && necho == 6 && didx < dstop && didx < dumpd.size()
                         && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b1; rx_byte = dumpd[didx]; didx++; last_rx_edge = e + 1;
            end
            #1;
            if (tx_valid && tx_ready) begin
                tx_q.push_back(tx_byte);
                pend  = 1;
                pbyte = (ntx == bad_idx) ? ~tx_byte : tx_byte;
                pdel  = $urandom_range(0, 3);
                ntx++;
            end
            if (wr_valid && wr_ready) pidx++;
            @(posedge CLK); e++;
            @(negedge CLK); budget++;
        end
        budget_used = budget;
        rx_valid = 1'b0; wr_valid = 1'b0;
        chk("run_bounded", 32'(budget < 3000), 32'd1);
    endtask

    task automatic fill(output b8_t q[$], input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(b8_t'($urandom));
    endtask

    initial begin
        logic [1:0]  rop;
        logic [15:0] rlen;
        logic [23:0] raddr;
        logic [1:0]  exp_ec;
        int          pulses;

        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_done_error", 32'({done, error, rd_valid, wr_ready}), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        reset_n = 1'b1;
        @(negedge CLK);
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        exp_ec = 2'd0;

        // Idle rx noise must be ignored.
        repeat (6) begin
            rx_valid = 1'($urandom_range(0, 1)); rx_byte = b8_t'($urandom);
            @(negedge CLK);
        end
        rx_valid = 1'b0;
        chk("idle_noise_busy", 32'({busy, tx_valid, rd_valid}), 32'd0);

        // EXEC with zero length.
        payload.delete(); dumpd.delete();
        run(2'd3, 24'h002000, 16'd0, -1, 0, -1);
        model(2'd3, 24'h002000, 16'd0, 6, 0, 0);
        cmp_q("exec_tx", tx_q, exp_tx);
        cmp_q("exec_rd", rd_q, exp_rd);
        chk("exec_done", 32'(done_n), 32'd1);
        chk("exec_err", 32'(err_n), 32'd0);

        // LOAD of three bytes.
        payload = '{8'hAA, 8'h55, 8'h01};
        run(2'd1, 24'h000010, 16'd3, -1, 0, -1);
        model(2'd1, 24'h000010, 16'd3, 6, 1, 0);
        cmp_q("load_tx", tx_q, exp_tx);
        chk("load_done", 32'(done_n), 32'd1);
        chk("load_err", 32'(err_n), 32'd0);

        // DUMP of two bytes.
        payload.delete(); dumpd = '{8'h12, 8'h34};
        run(2'd2, 24'h000000, 16'd2, -1, 2, -1);
        model(2'd2, 24'h000000, 16'd2, 6, 0, 2);
        cmp_q("dump_tx", tx_q, exp_tx);
        cmp_q("dump_rd", rd_q, exp_rd);
        chk("dump_done", 32'(done_n), 32'd1);

        // LOAD whose third header echo is corrupted.
        payload = '{8'h11, 8'h22};
        run(2'd1, 24'h000010, 16'd2, 2, 0, -1);
        model(2'd1, 24'h000010, 16'd2, 3, 0, 0);
        cmp_q("echo_err_tx", tx_q, exp_tx);
        chk("echo_err_pulse", 32'(err_n), 32'd1);
        chk("echo_err_done", 32'(done_n), 32'd0);
        chk("echo_err_code", 32'(last_ec), 32'd1);
        exp_ec = 2'd1;

        // DUMP of four where the responder goes silent after two bytes.
        payload.delete(); fill(dumpd, 4);
        run(2'd2, 24'h00ABCD, 16'd4, -1, 2, -1);
        model(2'd2, 24'h00ABCD, 16'd4, 6, 0, 2);
        cmp_q("to_rd", rd_q, exp_rd);
        chk("to_err_pulse", 32'(err_n), 32'd1);
        chk("to_err_code", 32'(last_ec), 32'd2);
        chk("to_latency", 32'(err_edge - last_rx_edge), 32'(TO));
        exp_ec = 2'd2;

        // Illegal op.
        dumpd.delete();
        run(2'd0, 24'h123456, 16'd5, -1, 0, -1);
        chk("ill_tx_count", 32'(tx_q.size()), 32'd0);
        chk("ill_err_edge", 32'(err_edge), 32'(acc_edge));
        chk("ill_err_code", 32'(last_ec), 32'd3);
        exp_ec = 2'd3;

        // Random legal commands.
        repeat (8) begin
            rop   = 2'($urandom_range(1, 3));
            rlen  = 16'($urandom_range(0, 5));
            raddr = 24'($urandom);
            if (rop == 2'd1) fill(payload, int'(rlen)); else payload.delete();
            if (rop == 2'd2) fill(dumpd, int'(rlen)); else dumpd.delete();
            run(rop, raddr, rlen, -1, int'(rlen), -1);
            model(rop, raddr, rlen, 6, rop == 2'd1, (rop == 2'd2) ? int'(rlen) : 0);
            cmp_q($sformatf("rnd_op%0d_tx", rop), tx_q, exp_tx);
            cmp_q($sformatf("rnd_op%0d_rd", rop), rd_q, exp_rd);
            chk("rnd_done", 32'(done_n), 32'd1);
            chk("rnd_err_code_hold", 32'(err_code), 32'(exp_ec));
        end

        // Reset in the middle of a LOAD payload.
        fill(payload, 4); dumpd.delete();
        run(2'd1, 24'h000400, 16'd4, -1, 0, 7);
        chk("mid_busy_before", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'({busy, tx_valid, wr_ready, rd_valid}), 32'd0);
        chk("mid_rst_err_code", 32'(err_code), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge CLK);
        reset_n = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(negedge CLK);
            pulses += int'(done) + int'(error);
        end
        chk("mid_rst_no_pulse", 32'(pulses), 32'd0);
        chk("mid_rst_done_in_run", 32'(done_n + err_n), 32'd0);

        // DUMP with zero length finishes after the header.
        payload.delete(); dumpd.delete();
        run(2'd2, 24'hFEDCBA, 16'd0, -1, 0, -1);
        model(2'd2, 24'hFEDCBA, 16'd0, 6, 0, 0);
        cmp_q("dump0_tx", tx_q, exp_tx);
        cmp_q("dump0_rd", rd_q, exp_rd);
        chk("dump0_done", 32'(done_n), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
